hbmc_dual_port_arbiter: RTL and testbench

Shares one OpenHBMC command/data port between two requesters (M0, M1), e.g. a CPU data path and a DMA engine contending for a single HyperRAM rank. Grants whole bursts, so a granted transaction completes before the other master is served. Arbitration is round-robin or fixed-priority. The block sits between the requesters and the HyperBus memory controller, in the controller clock domain.

---
 rtl/hbmc_dual_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_hbmc_dual_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbmc_dual_port_arbiter.sv
// Two-master burst arbiter in front of a single OpenHBMC command/data port.
// A granted master owns the controller for one whole burst (command plus all
// beats). The grant, state and beat counter are registered; the command,
// write and read paths are pure muxes with no buffering.
module hbmc_dual_port_arbiter #(
  parameter int    ADDR_WIDTH = 32,
  parameter int    DATA_WIDTH = 16,
  parameter int    LEN_WIDTH  = 8,
  parameter string ARB_MODE   = "RR"
) (
  input  logic                  clkin,
  input  logic                  resetn,
  // master 0
  input  logic                  m0_cmd_valid,
  output logic                  m0_cmd_ready,
  input  logic                  m0_cmd_we,
  input  logic [ADDR_WIDTH-1:0] m0_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  m0_cmd_len,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  output logic                  m0_rlast,
  input  logic                  m0_rready,
  // master 1
  input  logic                  m1_cmd_valid,
  output logic                  m1_cmd_ready,
  input  logic                  m1_cmd_we,
  input  logic [ADDR_WIDTH-1:0] m1_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  m1_cmd_len,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic                  m1_rlast,
  input  logic                  m1_rready,
  // controller side
  output logic                  hb_cmd_valid,
  input  logic                  hb_cmd_ready,
  output logic                  hb_cmd_we,
  output logic [ADDR_WIDTH-1:0] hb_cmd_addr,
  output logic [LEN_WIDTH-1:0]  hb_cmd_len,
  output logic [DATA_WIDTH-1:0] hb_wdata,
  output logic                  hb_wvalid,
  output logic                  hb_wlast,
  input  logic                  hb_wready,
  input  logic [DATA_WIDTH-1:0] hb_rdata,
  input  logic                  hb_rvalid,
  output logic                  hb_rready,
  // status
  output logic [1:0]            grant,
  output logic                  busy
);

  localparam bit RR_MODE = (ARB_MODE == "RR");

  // Reject unknown arbitration modes at elaboration time.
  if (ARB_MODE != "RR" && ARB_MODE != "FIXED") begin : g_bad_mode
    $error("hbmc_dual_port_arbiter: ARB_MODE must be \"RR\" or \"FIXED\"");
  end

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t               state_reg;
  logic [1:0]           grant_reg;
  logic                 last_m1_reg;   // 1 = M1 owned the previous burst
  logic [LEN_WIDTH-1:0] beat_cnt_reg;
  logic                 busy_reg;

  logic                 sel_m1;
  logic                 g_cmd_valid;
  logic                 g_cmd_we;
  logic [LEN_WIDTH-1:0] g_cmd_len;
  logic                 g_wvalid;
  logic                 g_rready;
  logic                 last_beat;
  logic                 pick_m1;
  logic                 in_cmd;
  logic                 in_wdata;
  logic                 in_rdata;
  logic [1:0]           cmd_ready_v;
  logic [1:0]           wready_v;
  logic [1:0]           rvalid_v;
  logic [1:0]           rlast_v;

  assign sel_m1      = grant_reg[1];
  assign g_cmd_valid = sel_m1 ? m1_cmd_valid : m0_cmd_valid;
  assign g_cmd_we    = sel_m1 ? m1_cmd_we    : m0_cmd_we;
  assign g_cmd_len   = sel_m1 ? m1_cmd_len   : m0_cmd_len;
  assign g_wvalid    = sel_m1 ? m1_wvalid    : m0_wvalid;
  assign g_rready    = sel_m1 ? m1_rready    : m0_rready;

  assign in_cmd    = (state_reg == CMD);
  assign in_wdata  = (state_reg == WDATA);
  assign in_rdata  = (state_reg == RDATA);
  assign last_beat = (beat_cnt_reg == '0);

  // M1 wins when it is the only requester, or on a round-robin tie when M0 went last.
  assign pick_m1 = m1_cmd_valid & (~m0_cmd_valid | (RR_MODE & ~last_m1_reg));

  // Controller-side muxes, gated by the phase of the burst.
  assign hb_cmd_valid = in_cmd & g_cmd_valid;
  assign hb_cmd_we    = g_cmd_we;
  assign hb_cmd_addr  = sel_m1 ? m1_cmd_addr : m0_cmd_addr;
  assign hb_cmd_len   = g_cmd_len;
  assign hb_wdata     = sel_m1 ? m1_wdata : m0_wdata;
  assign hb_wvalid    = in_wdata & g_wvalid;
  assign hb_wlast     = in_wdata & last_beat;
  assign hb_rready    = in_rdata & g_rready;

  // Handshake and status outputs only ever reach the granted master.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign cmd_ready_v[gi] = grant_reg[gi] & in_cmd   & hb_cmd_ready;
    assign wready_v[gi]    = grant_reg[gi] & in_wdata & hb_wready;
    assign rvalid_v[gi]    = grant_reg[gi] & in_rdata & hb_rvalid;
    assign rlast_v[gi]     = grant_reg[gi] & in_rdata & last_beat;
  end

  assign m0_cmd_ready = cmd_ready_v[0];
  assign m1_cmd_ready = cmd_ready_v[1];
  assign m0_wready    = wready_v[0];
  assign m1_wready    = wready_v[1];
  assign m0_rvalid    = rvalid_v[0];
  assign m1_rvalid    = rvalid_v[1];
  assign m0_rlast     = rlast_v[0];
  assign m1_rlast     = rlast_v[1];
  assign m0_rdata     = hb_rdata;
  assign m1_rdata     = hb_rdata;

  assign grant = grant_reg;
  assign busy  = busy_reg;

  // Burst FSM: arbitrate in IDLE, forward the command, then count beats down to zero.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      grant_reg    <= 2'b00;
      last_m1_reg  <= 1'b1;
      beat_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_cmd_valid | m1_cmd_valid) begin
            grant_reg <= pick_m1 ? 2'b10 : 2'b01;
            state_reg <= CMD;
            busy_reg  <= 1'b1;
          end
        end
        CMD: begin
          if (g_cmd_valid & hb_cmd_ready) begin
            beat_cnt_reg <= g_cmd_len;
            state_reg    <= g_cmd_we ? WDATA : RDATA;
          end
        end
        WDATA, RDATA: begin
          if (in_wdata ? (g_wvalid & hb_wready) : (hb_rvalid & g_rready)) begin
            if (last_beat) begin
              state_reg   <= IDLE;
              grant_reg   <= 2'b00;
              last_m1_reg <= grant_reg[1];
              busy_reg    <= 1'b0;
            end else begin
              beat_cnt_reg <= beat_cnt_reg - 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= 2'b00;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hbmc_dual_port_arbiter.sv
// Directed bench for hbmc_dual_port_arbiter: one round-robin instance and one
// fixed-priority instance share all stimulus; each step checks hand-computed values.
module tb_hbmc_dual_port_arbiter;

  logic        clkin = 1'b0;
  logic        resetn;
  logic        m0_cmd_valid, m0_cmd_we, m0_wvalid, m0_rready;
  logic [31:0] m0_cmd_addr;
  logic [7:0]  m0_cmd_len;
  logic [15:0] m0_wdata;
  logic        m1_cmd_valid, m1_cmd_we, m1_wvalid, m1_rready;
  logic [31:0] m1_cmd_addr;
  logic [7:0]  m1_cmd_len;
  logic [15:0] m1_wdata;
  logic        hb_cmd_ready, hb_wready, hb_rvalid;
  logic [15:0] hb_rdata;

  // round-robin instance outputs
  logic        m0_cmd_ready, m0_wready, m0_rvalid, m0_rlast;
  logic        m1_cmd_ready, m1_wready, m1_rvalid, m1_rlast;
  logic [15:0] m0_rdata, m1_rdata, hb_wdata;
  logic        hb_cmd_valid, hb_cmd_we, hb_wvalid, hb_wlast, hb_rready, busy;
  logic [31:0] hb_cmd_addr;
  logic [7:0]  hb_cmd_len;
  logic [1:0]  grant;

  // fixed-priority instance outputs
  logic        fx_m0_cmd_ready, fx_m0_wready, fx_m0_rvalid, fx_m0_rlast;
  logic        fx_m1_cmd_ready, fx_m1_wready, fx_m1_rvalid, fx_m1_rlast;
  logic [15:0] fx_m0_rdata, fx_m1_rdata, fx_hb_wdata;
  logic        fx_hb_cmd_valid, fx_hb_cmd_we, fx_hb_wvalid, fx_hb_wlast, fx_hb_rready, fx_busy;
  logic [31:0] fx_hb_cmd_addr;
  logic [7:0]  fx_hb_cmd_len;
  logic [1:0]  fx_grant;

  int vectors = 0;
  int miscompares = 0;

  hbmc_dual_port_arbiter #(.ARB_MODE("RR")) dut (
    .clkin(clkin), .resetn(resetn),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_we(m0_cmd_we),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_len(m0_cmd_len), .m0_wdata(m0_wdata),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_rdata(m0_rdata),
    .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_we(m1_cmd_we),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_len(m1_cmd_len), .m1_wdata(m1_wdata),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_rdata(m1_rdata),
    .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .hb_cmd_valid(hb_cmd_valid), .hb_cmd_ready(hb_cmd_ready), .hb_cmd_we(hb_cmd_we),
    .hb_cmd_addr(hb_cmd_addr), .hb_cmd_len(hb_cmd_len), .hb_wdata(hb_wdata),
    .hb_wvalid(hb_wvalid), .hb_wlast(hb_wlast), .hb_wready(hb_wready),
    .hb_rdata(hb_rdata), .hb_rvalid(hb_rvalid), .hb_rready(hb_rready),
    .grant(grant), .busy(busy)
  );

  hbmc_dual_port_arbiter #(.ARB_MODE("FIXED")) dut_fx (
    .clkin(clkin), .resetn(resetn),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(fx_m0_cmd_ready), .m0_cmd_we(m0_cmd_we),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_len(m0_cmd_len), .m0_wdata(m0_wdata),
    .m0_wvalid(m0_wvalid), .m0_wready(fx_m0_wready), .m0_rdata(fx_m0_rdata),
    .m0_rvalid(fx_m0_rvalid), .m0_rlast(fx_m0_rlast), .m0_rready(m0_rready),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(fx_m1_cmd_ready), .m1_cmd_we(m1_cmd_we),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_len(m1_cmd_len), .m1_wdata(m1_wdata),
    .m1_wvalid(m1_wvalid), .m1_wready(fx_m1_wready), .m1_rdata(fx_m1_rdata),
    .m1_rvalid(fx_m1_rvalid), .m1_rlast(fx_m1_rlast), .m1_rready(m1_rready),
    .hb_cmd_valid(fx_hb_cmd_valid), .hb_cmd_ready(hb_cmd_ready), .hb_cmd_we(fx_hb_cmd_we),
    .hb_cmd_addr(fx_hb_cmd_addr), .hb_cmd_len(fx_hb_cmd_len), .hb_wdata(fx_hb_wdata),
    .hb_wvalid(fx_hb_wvalid), .hb_wlast(fx_hb_wlast), .hb_wready(hb_wready),
    .hb_rdata(hb_rdata), .hb_rvalid(hb_rvalid), .hb_rready(fx_hb_rready),
    .grant(fx_grant), .busy(fx_busy)
  );

  always #5 clkin = ~clkin;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    resetn = 1'b0;
    m0_cmd_valid = 0; m0_cmd_we = 0; m0_cmd_addr = 0; m0_cmd_len = 0;
    m0_wdata = 0; m0_wvalid = 0; m0_rready = 0;
    m1_cmd_valid = 0; m1_cmd_we = 0; m1_cmd_addr = 0; m1_cmd_len = 0;
    m1_wdata = 0; m1_wvalid = 0; m1_rready = 0;
    hb_cmd_ready = 1; hb_wready = 1; hb_rvalid = 0; hb_rdata = 0;
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hb_cmd_valid", 32'(hb_cmd_valid), 32'h0);
    chk("rst_m0_cmd_ready", 32'(m0_cmd_ready), 32'h0);
    chk("rst_fx_grant", 32'(fx_grant), 32'h0);
    cyc(); cyc();
    resetn = 1'b1;

    // RR, both masters read continuously, len 1: M0, M1, M0, M1
    m0_cmd_valid = 1; m0_cmd_we = 0; m0_cmd_addr = 32'h200; m0_cmd_len = 8'd1;
    m1_cmd_valid = 1; m1_cmd_we = 0; m1_cmd_addr = 32'h300; m1_cmd_len = 8'd1;
    m0_rready = 1; m1_rready = 1; hb_rvalid = 1; hb_rdata = 16'h1234;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("t2_idle_grant", 32'(grant), 32'h0);
      chk("t2_idle_busy", 32'(busy), 32'h0);
      cyc();
      chk("t2_cmd_grant", 32'(grant), 32'(exp_g));
      chk("t2_cmd_addr", hb_cmd_addr, (k % 2 == 0) ? 32'h200 : 32'h300);
      chk("t2_cmd_valid", 32'(hb_cmd_valid), 32'h1);
      cyc();
      chk("t2_b1_m0_rvalid", 32'(m0_rvalid), 32'(k % 2 == 0));
      chk("t2_b1_m1_rvalid", 32'(m1_rvalid), 32'(k % 2 == 1));
      chk("t2_b1_rlast", 32'(m0_rlast | m1_rlast), 32'h0);
      cyc();
      chk("t2_b2_m0_rlast", 32'(m0_rlast), 32'(k % 2 == 0));
      chk("t2_b2_m1_rlast", 32'(m1_rlast), 32'(k % 2 == 1));
      chk("t2_b2_rdata", 32'(exp_g[0] ? m0_rdata : m1_rdata), 32'h1234);
      cyc();
    end
    chk("t2_end_grant", 32'(grant), 32'h0);
    m0_cmd_valid = 0; m1_cmd_valid = 0; hb_rvalid = 0;

    // M0 write, addr 0x100, len 3
    cyc();
    m0_cmd_valid = 1; m0_cmd_we = 1; m0_cmd_addr = 32'h100; m0_cmd_len = 8'd3;
    #1;
    chk("t1_pre_cmd_valid", 32'(hb_cmd_valid), 32'h0);
    cyc();
    chk("t1_cmd_valid", 32'(hb_cmd_valid), 32'h1);
    chk("t1_cmd_addr", hb_cmd_addr, 32'h100);
    chk("t1_cmd_len", 32'(hb_cmd_len), 32'h3);
    chk("t1_cmd_we", 32'(hb_cmd_we), 32'h1);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_m0_cmd_ready", 32'(m0_cmd_ready), 32'h1);
    chk("t1_m1_cmd_ready", 32'(m1_cmd_ready), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    cyc();
    m0_cmd_valid = 0; m0_wvalid = 1;
    for (int i = 0; i < 4; i++) begin
      m0_wdata = 16'hA000 + 16'(i);
      #1;
      chk("t1_wvalid", 32'(hb_wvalid), 32'h1);
      chk("t1_wdata", 32'(hb_wdata), 32'hA000 + 32'(i));
      chk("t1_wlast", 32'(hb_wlast), 32'(i == 3));
      chk("t1_m0_wready", 32'(m0_wready), 32'h1);
      chk("t1_m1_wready", 32'(m1_wready), 32'h0);
      cyc();
    end
    #1;
    chk("t1_end_grant", 32'(grant), 32'h0);
    chk("t1_end_busy", 32'(busy), 32'h0);
    chk("t1_end_wvalid", 32'(hb_wvalid), 32'h0);
    m0_wvalid = 0;

    // M0 write, len 0: a single beat carrying wlast
    cyc();
    m0_cmd_valid = 1; m0_cmd_we = 1; m0_cmd_addr = 32'h40; m0_cmd_len = 8'd0;
    cyc();
    chk("t5_grant", 32'(grant), 32'h1);
    cyc();
    m0_cmd_valid = 0; m0_wvalid = 1; m0_wdata = 16'h5555;
    #1;
    chk("t5_wvalid", 32'(hb_wvalid), 32'h1);
    chk("t5_wlast", 32'(hb_wlast), 32'h1);
    cyc();
    chk("t5_end_busy", 32'(busy), 32'h0);
    chk("t5_end_wlast", 32'(hb_wlast), 32'h0);
    m0_wvalid = 0;

    // M1 read, len 1, with m1_rready held low for 5 cycles
    cyc();
    m1_cmd_valid = 1; m1_cmd_we = 0; m1_cmd_addr = 32'h500; m1_cmd_len = 8'd1;
    cyc();
    chk("t4_grant", 32'(grant), 32'h2);
    cyc();
    m1_cmd_valid = 0; m1_rready = 0; hb_rvalid = 1; hb_rdata = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_stall_hb_rready", 32'(hb_rready), 32'h0);
      chk("t4_stall_m1_rvalid", 32'(m1_rvalid), 32'h1);
      chk("t4_stall_rdata", 32'(m1_rdata), 32'hBEEF);
      chk("t4_stall_m0_rvalid", 32'(m0_rvalid), 32'h0);
      cyc();
    end
    m1_rready = 1;
    #1;
    chk("t4_b1_hb_rready", 32'(hb_rready), 32'h1);
    chk("t4_b1_rlast", 32'(m1_rlast), 32'h0);
    cyc();
    hb_rdata = 16'hBEF0;
    #1;
    chk("t4_b2_rlast", 32'(m1_rlast), 32'h1);
    cyc();
    chk("t4_end_grant", 32'(grant), 32'h0);
    hb_rvalid = 0; m1_rready = 0;

    // Reset during beat 3 of an 8-beat write, then an M1 read
    cyc();
    m0_cmd_valid = 1; m0_cmd_we = 1; m0_cmd_addr = 32'h800; m0_cmd_len = 8'd7;
    cyc();
    cyc();
    m0_cmd_valid = 0; m0_wvalid = 1;
    cyc();
    cyc();
    #1;
    chk("t6_beat3_wvalid", 32'(hb_wvalid), 32'h1);
    chk("t6_beat3_wlast", 32'(hb_wlast), 32'h0);
    resetn = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_wvalid", 32'(hb_wvalid), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_wready", 32'(m0_wready), 32'h0);
    m0_wvalid = 0;
    cyc();
    resetn = 1'b1;
    m1_cmd_valid = 1; m1_cmd_we = 0; m1_cmd_addr = 32'h900; m1_cmd_len = 8'd0;
    #1;
    chk("t6_post_idle_grant", 32'(grant), 32'h0);
    cyc();
    chk("t6_post_grant", 32'(grant), 32'h2);
    chk("t6_post_cmd_valid", 32'(hb_cmd_valid), 32'h1);
    chk("t6_post_cmd_addr", hb_cmd_addr, 32'h900);
    cyc();
    m1_cmd_valid = 0; m1_rready = 1; hb_rvalid = 1;
    #1;
    chk("t6_post_rlast", 32'(m1_rlast), 32'h1);
    cyc();
    chk("t6_post_busy", 32'(busy), 32'h0);
    hb_rvalid = 0; m1_rready = 0;

    // FIXED: M0 always wins while requesting; M1 gets in once M0 drops
    resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    m0_cmd_valid = 1; m0_cmd_we = 0; m0_cmd_addr = 32'h10; m0_cmd_len = 8'd0;
    m1_cmd_valid = 1; m1_cmd_we = 0; m1_cmd_addr = 32'h20; m1_cmd_len = 8'd0;
    m0_rready = 1; m1_rready = 1; hb_rvalid = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t3_idle_grant", 32'(fx_grant), 32'h0);
      cyc();
      chk("t3_cmd_grant", 32'(fx_grant), 32'h1);
      cyc();
      chk("t3_m0_rlast", 32'(fx_m0_rlast), 32'h1);
      chk("t3_m1_rvalid", 32'(fx_m1_rvalid), 32'h0);
      cyc();
    end
    m0_cmd_valid = 0;
    #1;
    chk("t3_gap_grant", 32'(fx_grant), 32'h0);
    cyc();
    chk("t3_m1_grant", 32'(fx_grant), 32'h2);
    chk("t3_m1_addr", fx_hb_cmd_addr, 32'h20);
    cyc();
    m1_cmd_valid = 0;
    #1;
    chk("t3_m1_rlast", 32'(fx_m1_rlast), 32'h1);
    cyc();
    chk("t3_end_busy", 32'(fx_busy), 32'h0);
    hb_rvalid = 0; m0_rready = 0; m1_rready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
